cs_out_checker: RTL and testbench
=================================

CS_OUT_CHECKER -- requirements
Module: cs_out_checker

Interface
REQ-001 Parameter: N_CHECK, 1992, number of Y samples compared per run.
REQ-002 Parameter: WARMUP, 9, clk cycles from start acceptance to the first compare.
REQ-003 Parameter: FIFO_DEPTH, 4, expected-value buffer entries (power of 2, >=2).
REQ-004 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: start  in  1  one-cycle run request; honoured only in IDLE.
REQ-007 Port: Y  in  10  CS output stream under check, sampled every posedge in CHECK.
REQ-008 Port: exp_data  in  10  golden value for the next compare.
REQ-009 Port: exp_valid  in  1  exp_data is valid.
REQ-010 Port: exp_ready  out  1  FIFO not full; a push occurs when exp_valid && exp_ready.
REQ-011 Port: busy  out  1  high in WARMUP or CHECK.
REQ-012 Port: done  out  1  high in DONE.
REQ-013 Port: pass  out  1  high in DONE when err_cnt==0 and underrun==0.
REQ-014 Port: err_cnt  out  16  mismatch count, saturating at 16'hFFFF.
REQ-015 Port: chk_cnt  out  16  compares performed in the current run.
REQ-016 Port: underrun  out  1  sticky; a compare found the FIFO empty.

Function
REQ-017 FSM states: IDLE, WARMUP, CHECK, DONE.
REQ-018 IDLE->WARMUP on start; this clears err_cnt, chk_cnt and underrun and loads the warm-up counter with WARMUP-1.
REQ-019 WARMUP: the counter decrements each cycle; at 0 the FSM moves to CHECK, so the first compare is at the WARMUP-th posedge after start.
REQ-020 CHECK: each cycle compares Y to the FIFO head, pops the head, and increments chk_cnt.
REQ-021 Mismatch (Y != head, 4-state inequality treated as mismatch for X/Z at gate level) increments err_cnt.
REQ-022 CHECK with the FIFO empty sets underrun and increments both err_cnt and chk_cnt; no pop occurs.
REQ-023 CHECK->DONE on the cycle chk_cnt reaches N_CHECK; no further compares or pops occur.
REQ-024 DONE->IDLE on start; this behaves as IDLE->WARMUP, i.e. back-to-back runs need no idle cycle.
REQ-025 start is ignored in WARMUP and CHECK.
REQ-026 The FIFO accepts pushes in every state.
REQ-027 Push and pop in the same cycle: occupancy is unchanged; a push into a full FIFO is legal only if a pop occurs in that cycle, and exp_ready reflects pre-pop state (conservative).
REQ-028 The FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter width is clog2(FIFO_DEPTH)+1.
REQ-029 Outputs are registered; done, pass, busy and the counters reflect state after the current edge, with no combinational path from Y.

Reset
REQ-030 reset has priority over all other inputs, including start.
REQ-031 Reset values: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, chk_cnt=0, underrun=0, FIFO empty, exp_ready=1.
REQ-032 Reset mid-run aborts the run, discards FIFO contents, and does not assert done.

Structure
REQ-033 Shared package cs_pkg: state enum, Y width constant (10), X width constant (8), default N_CHECK and WARMUP.
REQ-034 One sub-module: cs_exp_fifo (synchronous FIFO, DEPTH parameter, full/empty/push/pop), instantiated once.

Verification
REQ-035 Reset, push 4 golden values, start, drive Y matching -> first compare at cycle 9 after start; with N_CHECK=4, done=1, pass=1, err_cnt=0 at cycle 12.
REQ-036 N_CHECK=4, third Y = 10'h3FF vs golden 10'h0A5 -> err_cnt=1, pass=0, done=1.
REQ-037 N_CHECK=4, push only 2 values -> underrun=1, err_cnt=2, chk_cnt=4, pass=0.
REQ-038 Fill FIFO (4 entries), hold exp_valid=1 during CHECK -> exp_ready=0 while full, no value lost, pushes accepted as pops occur, full run passes.
REQ-039 Assert reset on CHECK cycle 2 -> all outputs return to reset values next cycle, done never pulses; a fresh start then runs cleanly.
REQ-040 Full-length run with N_CHECK=1992 against 1992 golden values -> done after 9+1991 cycles, pass=1; start while busy changes nothing.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared types and constants for the CS output checker: FSM states, stream widths,
// default run length and warm-up latency.
package cs_pkg;

    localparam int Y_W         = 10;
    localparam int X_W         = 8;
    localparam int N_CHECK_DEF = 1992;
    localparam int WARMUP_DEF  = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Error counters stick at all-ones instead of wrapping back to a clean-looking value.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cs_exp_fifo.sv
// Small synchronous FIFO holding golden values; head is visible without a read
// cycle so the checker can compare and pop in the same clock.
module cs_exp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         i_srst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [W-1:0]  w_entry [DEPTH];
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop && !o_empty;
    // A push into a full buffer is only safe when the head leaves in the same cycle.
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = w_entry[r_rd_ptr];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [W-1:0] r_data;
            always_ff @(posedge clk) begin
                if (w_push && (r_wr_ptr == AW'(gi))) begin
                    r_data <= i_data;
                end
            end
            assign w_entry[gi] = r_data;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (i_srst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cs_out_checker.sv
// Compares a CS output stream against buffered golden values for a fixed number of
// samples after a warm-up delay, reporting mismatch/underrun counts and a pass flag.
module cs_out_checker
    import cs_pkg::*;
#(
    parameter int N_CHECK    = N_CHECK_DEF,
    parameter int WARMUP     = WARMUP_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [Y_W-1:0] Y,
    input  logic [Y_W-1:0] exp_data,
    input  logic           exp_valid,
    output logic           exp_ready,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [15:0]    err_cnt,
    output logic [15:0]    chk_cnt,
    output logic           underrun
);

    localparam int          WU_W        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam state_t      START_STATE = (WARMUP > 1) ? ST_WARMUP : ST_CHECK;
    localparam logic [15:0] LAST_CHK    = 16'(N_CHECK);

    state_t          r_state, w_state_next;
    logic [WU_W-1:0] r_wu_cnt, w_wu_cnt_next;
    logic [15:0]     r_err_cnt, w_err_cnt_next;
    logic [15:0]     r_chk_cnt, w_chk_cnt_next;
    logic            r_underrun, w_underrun_next;
    logic            r_pass, w_pass_next;
    logic            r_busy;
    logic            r_done;

    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_mismatch;
    logic [Y_W-1:0]  w_head;

    assign exp_ready = !w_full;
    assign w_push    = exp_valid && !w_full;

    cs_exp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (Y_W)
    ) u_exp_fifo (
        .clk     (clk),
        .i_srst  (reset),
        .i_push  (w_push),
        .i_data  (exp_data),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_state_next    = r_state;
        w_wu_cnt_next   = r_wu_cnt;
        w_err_cnt_next  = r_err_cnt;
        w_chk_cnt_next  = r_chk_cnt;
        w_underrun_next = r_underrun;
        w_pass_next     = r_pass;
        w_pop           = 1'b0;
        // Written as if/else so an unknown compare result lands on the mismatch side.
        if (Y == w_head) begin
            w_mismatch = 1'b0;
        end else begin
            w_mismatch = 1'b1;
        end

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_next    = START_STATE;
                    w_wu_cnt_next   = WU_W'(WARMUP - 1);
                    w_err_cnt_next  = '0;
                    w_chk_cnt_next  = '0;
                    w_underrun_next = 1'b0;
                    w_pass_next     = 1'b0;
                end
            end
            ST_WARMUP: begin
                // Leave one cycle early so the first compare lands on the WARMUP-th edge.
                if (r_wu_cnt <= WU_W'(1)) begin
                    w_state_next  = ST_CHECK;
                    w_wu_cnt_next = '0;
                end else begin
                    w_wu_cnt_next = r_wu_cnt - 1'b1;
                end
            end
            ST_CHECK: begin
                w_chk_cnt_next = r_chk_cnt + 16'd1;
                if (w_empty) begin
                    w_underrun_next = 1'b1;
                    w_err_cnt_next  = sat_inc16(r_err_cnt);
                end else begin
                    w_pop = 1'b1;
                    if (w_mismatch) begin
                        w_err_cnt_next = sat_inc16(r_err_cnt);
                    end
                end
                if (w_chk_cnt_next == LAST_CHK) begin
                    w_state_next = ST_DONE;
                    w_pass_next  = (w_err_cnt_next == '0) && !w_underrun_next;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wu_cnt   <= '0;
            r_err_cnt  <= '0;
            r_chk_cnt  <= '0;
            r_underrun <= 1'b0;
            r_pass     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wu_cnt   <= w_wu_cnt_next;
            r_err_cnt  <= w_err_cnt_next;
            r_chk_cnt  <= w_chk_cnt_next;
            r_underrun <= w_underrun_next;
            r_pass     <= w_pass_next;
            r_busy     <= (w_state_next == ST_WARMUP) || (w_state_next == ST_CHECK);
            r_done     <= (w_state_next == ST_DONE);
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign chk_cnt  = r_chk_cnt;
    assign underrun = r_underrun;

endmodule

// File: tb/tb_cs_out_checker.sv
// Directed/random bench for cs_out_checker: a short-run instance (N_CHECK=4) and a
// full-length instance, both checked every cycle against a queue-based reference model.
module tb_cs_out_checker;
    import cs_pkg::*;

    localparam int DEPTH = 4;
    localparam int WU    = 9;
    localparam int NA    = 4;
    localparam int NB    = 1992;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_start, b_start, a_ev, b_ev;
    logic [9:0]  a_y, b_y, a_ed, b_ed;
    logic        a_ready, a_busy, a_done, a_pass, a_under;
    logic        b_ready, b_busy, b_done, b_pass, b_under;
    logic [15:0] a_err, a_chk, b_err, b_chk;

    cs_out_checker #(.N_CHECK(NA), .WARMUP(WU), .FIFO_DEPTH(DEPTH)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .Y(a_y), .exp_data(a_ed),
        .exp_valid(a_ev), .exp_ready(a_ready), .busy(a_busy), .done(a_done),
        .pass(a_pass), .err_cnt(a_err), .chk_cnt(a_chk), .underrun(a_under)
    );

    cs_out_checker #(.N_CHECK(NB), .WARMUP(WU), .FIFO_DEPTH(DEPTH)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .Y(b_y), .exp_data(b_ed),
        .exp_valid(b_ev), .exp_ready(b_ready), .busy(b_busy), .done(b_done),
        .pass(b_pass), .err_cnt(b_err), .chk_cnt(b_chk), .underrun(b_under)
    );

    int sel = 0;
    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;

    logic o_busy, o_done, o_pass, o_under, o_ready;
    logic [15:0] o_err, o_chk;
    assign o_busy  = (sel == 1) ? b_busy  : a_busy;
    assign o_done  = (sel == 1) ? b_done  : a_done;
    assign o_pass  = (sel == 1) ? b_pass  : a_pass;
    assign o_under = (sel == 1) ? b_under : a_under;
    assign o_ready = (sel == 1) ? b_ready : a_ready;
    assign o_err   = (sel == 1) ? b_err   : a_err;
    assign o_chk   = (sel == 1) ? b_chk   : a_chk;

    // Reference model: golden values still owed, and where we are in the run.
    logic [9:0] mq[$];
    bit m_busy, m_done, m_pass, m_under;
    int m_k, m_err, m_chk;

    function automatic logic [9:0] gold();
        return (mq.size() > 0) ? mq[0] : 10'h155;
    endfunction

    function automatic logic [9:0] rnd10();
        return 10'($urandom);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input bit rst, input bit st, input logic [9:0] y,
                              input bit ev, input logic [9:0] ed);
        int  n;
        bit  acc;
        n = (sel == 1) ? NB : NA;
        if (rst) begin
            mq.delete();
            m_busy = 0; m_done = 0; m_pass = 0; m_under = 0;
            m_k = 0; m_err = 0; m_chk = 0;
            return;
        end
        acc = ev && (mq.size() < DEPTH);
        if (m_busy) begin
            m_k++;
            if (m_k >= WU) begin
                m_chk++;
                if (mq.size() == 0) begin
                    m_under = 1;
                    if (m_err < 65535) m_err++;
                end else begin
                    if (y !== mq[0] && m_err < 65535) m_err++;
                    void'(mq.pop_front());
                end
                if (m_chk == n) begin
                    m_busy = 0;
                    m_done = 1;
                    m_pass = (m_err == 0) && !m_under;
                end
            end
        end else if (st) begin
            m_busy = 1; m_k = 0; m_err = 0; m_chk = 0;
            m_under = 0; m_done = 0; m_pass = 0;
        end
        if (acc) mq.push_back(ed);
    endtask

    task automatic check_all();
        check("busy",      16'(o_busy),  16'(m_busy));
        check("done",      16'(o_done),  16'(m_done));
        check("pass",      16'(o_pass),  16'(m_pass));
        check("underrun",  16'(o_under), 16'(m_under));
        check("err_cnt",   o_err,        16'(m_err));
        check("chk_cnt",   o_chk,        16'(m_chk));
        check("exp_ready", 16'(o_ready), 16'(mq.size() < DEPTH));
    endtask

    task automatic step(input bit rst, input bit st, input logic [9:0] y,
                        input bit ev, input logic [9:0] ed);
        reset = rst;
        a_start = 0; a_y = '0; a_ev = 0; a_ed = '0;
        b_start = 0; b_y = '0; b_ev = 0; b_ed = '0;
        if (sel == 1) begin
            b_start = st; b_y = y; b_ev = ev; b_ed = ed;
        end else begin
            a_start = st; a_y = y; a_ev = ev; a_ed = ed;
        end
        @(posedge clk);
        model_edge(rst, st, y, ev, ed);
        cyc++;
        #1;
        check_all();
    endtask

    initial begin
        logic [9:0] v;

        // Reset values
        step(1, 0, '0, 0, '0);
        step(1, 0, '0, 0, '0);
        step(0, 0, '0, 0, '0);

        // Clean run: 4 golden values, matching Y, done at edge 12 after start
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, rnd10());
        step(0, 1, '0, 0, '0);
        for (int i = 0; i < 14; i++) step(0, 0, gold(), 0, '0);
        check("clean_done", 16'(a_done), 16'd1);
        check("clean_pass", 16'(a_pass), 16'd1);

        // Single mismatch on third compare, started straight from DONE
        v = 10'h0A5;
        step(0, 0, '0, 1, rnd10());
        step(0, 0, '0, 1, rnd10());
        step(0, 0, '0, 1, v);
        step(0, 0, '0, 1, rnd10());
        step(0, 1, '0, 0, '0);
        for (int i = 0; i < 14; i++)
            step(0, 0, (m_busy && m_chk == 2) ? 10'h3FF : gold(), 0, '0);
        check("mis_err", a_err, 16'd1);

        // Underrun: only two golden values
        for (int i = 0; i < 2; i++) step(0, 0, '0, 1, rnd10());
        step(0, 1, '0, 0, '0);
        for (int i = 0; i < 14; i++) step(0, 0, gold(), 0, '0);
        check("under_err", a_err, 16'd2);

        // Full FIFO with exp_valid held high throughout; start pulse mid-warm-up ignored
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, rnd10());
        step(0, 1, '0, 1, rnd10());
        for (int i = 0; i < 14; i++) step(0, (i == 3), gold(), 1, rnd10());
        check("full_pass", 16'(a_pass), 16'd1);

        // Reset during CHECK after two compares, then a fresh run
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, rnd10());
        step(0, 1, '0, 0, '0);
        for (int i = 0; i < 20 && !(m_busy && m_chk == 2); i++) step(0, 0, gold(), 0, '0);
        step(1, 0, gold(), 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, rnd10());
        step(0, 1, '0, 0, '0);
        for (int i = 0; i < 14; i++) step(0, 0, gold(), 0, '0);
        check("rerun_pass", 16'(a_pass), 16'd1);

        // Random runs: random pushes, random mismatches, stray start pulses
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < int'($urandom_range(0, 4)); i++) step(0, 0, '0, 1, rnd10());
            step(0, 1, '0, 1'($urandom_range(0, 1)), rnd10());
            for (int i = 0; i < 14; i++)
                step(0, ($urandom_range(0, 9) == 0) && m_busy,
                     ($urandom_range(0, 3) == 0) ? rnd10() : gold(),
                     1'($urandom_range(0, 1)), rnd10());
        end

        // Full-length run on the second instance
        sel = 1;
        step(1, 0, '0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 1, rnd10());
        step(0, 1, '0, 1, rnd10());
        for (int i = 0; i < NB + WU + 4; i++)
            step(0, m_busy && m_chk < NB - 5 && ($urandom_range(0, 96) == 0),
                 gold(), 1, rnd10());
        check("long_done", 16'(b_done), 16'd1);
        check("long_pass", 16'(b_pass), 16'd1);
        check("long_chk",  b_chk, 16'(NB));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
